// File: rtl/uint2float_pkg.sv
// Shared constants and the stage-2 register layout for the unsigned-to-float converter.
package uint2float_pkg;

    localparam int unsigned FP_EXP_W = 8;
    localparam int unsigned FP_MAN_W = 23;
    localparam int unsigned FP_BIAS  = 127;
    localparam int unsigned UINT_W   = 32;

    typedef struct packed {
        logic                zero;
        logic [FP_EXP_W-1:0] exp;
        logic [UINT_W-1:0]   m;
    } s2_t;

endpackage

// File: rtl/uint2float_clz.sv
// Combinational 32-bit leading-zero counter: halving tree yielding a 5-bit count and an all-zero flag.
module uint2float_clz
    import uint2float_pkg::*;
(
    input  logic [UINT_W-1:0] a,
    output logic [4:0]        cnt,
    output logic              all_zero
);

    logic [UINT_W-1:0] v;

    // Each level tests the upper half of what is left and shifts it out when it is empty.
    always_comb begin
        v   = a;
        cnt = '0;
        if (v[31:16] == '0) begin
            cnt[4] = 1'b1;
            v      = v << 16;
        end
        if (v[31:24] == '0) begin
            cnt[3] = 1'b1;
            v      = v << 8;
        end
        if (v[31:28] == '0) begin
            cnt[2] = 1'b1;
            v      = v << 4;
        end
        if (v[31:30] == '0) begin
            cnt[1] = 1'b1;
            v      = v << 2;
        end
        if (v[31] == 1'b0) begin
            cnt[0] = 1'b1;
        end
        all_zero = (a == '0);
    end

endmodule

// File: rtl/uint2float_unit.sv
// Versat unit: 32-bit unsigned integer to IEEE-754 single, 3-stage pipeline (capture, normalize, pack).
// Define UINT2FLOAT_RNE_EN for round-to-nearest-even; otherwise the mantissa is truncated.
module uint2float_unit
    import uint2float_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              running,
    input  logic              run,
    input  logic [DATA_W-1:0] in0,
    (* versat_latency = 3 *)
    output logic [DATA_W-1:0] out0
);

    if (DATA_W != 32) begin : g_bad_width
        $error("uint2float_unit supports only DATA_W = 32");
    end

    // Exponent of a value whose MSB sits at bit 31, before subtracting leading zeros.
    localparam logic [FP_EXP_W-1:0] EXP_TOP = FP_EXP_W'(FP_BIAS + UINT_W - 1);

    logic [DATA_W-1:0] s1_q;
    s2_t               s2_d, s2_q;
    logic [DATA_W-1:0] out_d;

    logic [4:0] lz;
    logic       lz_zero;

    uint2float_clz u_clz (
        .a        (s1_q),
        .cnt      (lz),
        .all_zero (lz_zero)
    );

    always_comb begin
        s2_d      = '0;
        s2_d.zero = lz_zero;
        s2_d.m    = s1_q << lz;
        s2_d.exp  = EXP_TOP - {3'b000, lz};
    end

    logic [FP_EXP_W-1:0] exp_r;
    logic [FP_MAN_W-1:0] man_r;

`ifdef UINT2FLOAT_RNE_EN
    logic            guard, sticky, inc;
    logic [FP_MAN_W:0] man_sum;

    always_comb begin
        guard   = s2_q.m[7];
        sticky  = |s2_q.m[6:0];
        inc     = guard & (sticky | s2_q.m[8]);
        man_sum = {1'b0, s2_q.m[30:8]} + {{FP_MAN_W{1'b0}}, inc};
        // A carry out leaves the mantissa all-zero and bumps the exponent; max exp stays 159.
        man_r   = man_sum[FP_MAN_W-1:0];
        exp_r   = s2_q.exp + {{(FP_EXP_W-1){1'b0}}, man_sum[FP_MAN_W]};
    end
`else
    always_comb begin
        man_r = s2_q.m[30:8];
        exp_r = s2_q.exp;
    end
`endif

    always_comb begin
        out_d = '0;
        if (!s2_q.zero) begin
            out_d = {1'b0, exp_r, man_r};
        end
    end

    logic unused_bits;
    assign unused_bits = ^{s2_q.m[31], s2_q.m[7:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
            out0 <= '0;
        end else if (run) begin
            s1_q <= '0;
            s2_q <= '0;
            out0 <= '0;
        end else if (running) begin
            s1_q <= in0;
            s2_q <= s2_d;
            out0 <= out_d;
        end
    end

endmodule

// File: tb/tb_uint2float_unit.sv
// Directed and random self-checking bench for uint2float_unit; follows UINT2FLOAT_RNE_EN like the RTL.
module tb_uint2float_unit;

    logic        clk;
    logic        rst_n;
    logic        running;
    logic        run;
    logic [31:0] in0;
    logic [31:0] out0;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] vin[$];
    logic [31:0] vexp[$];

    uint2float_unit #(.DATA_W(32)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .running (running),
        .run     (run),
        .in0     (in0),
        .out0    (out0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Reference built from the exact double value of the integer.
    function automatic logic [31:0] ref_u2f(input logic [31:0] x);
        longint    li;
        real       r;
        logic [63:0] d;
        logic [10:0] e11;
        logic [7:0]  e;
        logic        inc;
        if (x == 32'd0) return 32'd0;
        li  = {32'd0, x};
        r   = real'(li);
        d   = $realtobits(r);
        e11 = d[62:52] - 11'd896;
        e   = e11[7:0];
`ifdef UINT2FLOAT_RNE_EN
        inc = d[28] & ((|d[27:0]) | d[29]);
`else
        inc = 1'b0;
`endif
        return {1'b0, e, d[51:29]} + {31'd0, inc};
    endfunction

    // Feeds vin one per cycle with running high; out0 seen at negedge j reflects input j-3.
    task automatic run_stream(input string tag);
        int n;
        n = vin.size();
        for (int i = 0; i < n + 3; i++) begin
            @(negedge clk);
            if (i >= 3) check_eq($sformatf("%s[%0d] in=%08h", tag, i - 3, vin[i-3]), out0, vexp[i-3]);
            in0 = (i < n) ? vin[i] : 32'd0;
        end
    endtask

    task automatic add_vec(input logic [31:0] x, input logic [31:0] y);
        vin.push_back(x);
        vexp.push_back(y);
    endtask

    initial begin
        rst_n   = 1'b0;
        running = 1'b0;
        run     = 1'b0;
        in0     = 32'd0;
        #12;
        check_eq("reset_out0", out0, 32'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        running = 1'b1;

        add_vec(32'h0000_0000, 32'h0000_0000);
        add_vec(32'h0000_0001, 32'h3F80_0000);
        add_vec(32'h8000_0000, 32'h4F00_0000);
        add_vec(32'h00FF_FFFF, 32'h4B7F_FFFF);
        add_vec(32'h0100_0000, 32'h4B80_0000);
`ifdef UINT2FLOAT_RNE_EN
        add_vec(32'h0100_0003, 32'h4B80_0002);
        add_vec(32'hFFFF_FFFF, 32'h4F80_0000);
        add_vec(32'h7FFF_FFFF, 32'h4F00_0000);
`else
        add_vec(32'h0100_0003, 32'h4B80_0001);
        add_vec(32'hFFFF_FFFF, 32'h4F7F_FFFF);
        add_vec(32'h7FFF_FFFF, 32'h4EFF_FFFF);
`endif
        add_vec(32'h0000_0005, 32'h40A0_0000);
        run_stream("directed");

        // Stall: two held edges once the first result has reached out0.
        @(negedge clk); in0 = 32'd1;
        @(negedge clk); in0 = 32'd2;
        @(negedge clk); in0 = 32'd3;
        @(negedge clk);
        check_eq("stall_pre", out0, 32'h3F80_0000);
        running = 1'b0; in0 = 32'd4;
        @(negedge clk);
        check_eq("stall_hold0", out0, 32'h3F80_0000);
        @(negedge clk);
        check_eq("stall_hold1", out0, 32'h3F80_0000);
        running = 1'b1;
        @(negedge clk);
        check_eq("stall_seq2", out0, 32'h4000_0000);
        in0 = 32'd0;
        @(negedge clk);
        check_eq("stall_seq3", out0, 32'h4040_0000);
        @(negedge clk);
        check_eq("stall_seq4", out0, 32'h4080_0000);
        @(negedge clk);
        check_eq("stall_drain", out0, 32'h0000_0000);

        // Flush with three values in flight.
        in0 = 32'd5;
        @(negedge clk); in0 = 32'd6;
        @(negedge clk); in0 = 32'd7;
        @(negedge clk);
        check_eq("flush_pre", out0, 32'h40A0_0000);
        run = 1'b1; in0 = 32'd8;
        @(negedge clk);
        check_eq("flush_edge", out0, 32'd0);
        run = 1'b0; in0 = 32'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq($sformatf("flush_stale%0d", i), out0, 32'd0);
        end

        // Asynchronous reset mid-cycle with data in flight.
        in0 = 32'd9;
        @(negedge clk); in0 = 32'd10;
        @(negedge clk); in0 = 32'd11;
        @(negedge clk);
        check_eq("areset_pre", out0, 32'h4110_0000);
        in0 = 32'd0;
        #2 rst_n = 1'b0;
        #1 check_eq("areset_now", out0, 32'd0);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq($sformatf("areset_stale%0d", i), out0, 32'd0);
        end

        vin.delete();
        vexp.delete();
        for (int i = 0; i < 10000; i++) begin
            logic [31:0] x;
            x = $urandom;
            if (i % 4 == 1) x = x >> $urandom_range(31, 1);
            add_vec(x, ref_u2f(x));
        end
        run_stream("random");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uint2float_unit.md
# uint2float_unit

Versat functional unit converting a 32-bit unsigned integer to an IEEE-754 single-precision float. It is the reverse of the float-to-unsigned converter unit and plugs into the same Versat datapath (`running`/`run` control, `in0`/`out0` data). It is a fixed 3-stage pipeline: capture, normalize, round/pack. The unit is tagged `versat_latency = 3` so the Versat scheduler aligns it with other units.

## Interface
Parameters:
- `DATA_W`, default 32. Data width. Only 32 is supported; any other value is an elaboration error.

Ports:
- `clk`, input, 1. Clock; all state on the rising edge.
- `rst_n`, input, 1. Reset: asynchronous, active-low. The clock is the only clock in the unit.
- `running`, input, 1. Pipeline advance enable.
- `run`, input, 1. Single-cycle run-start pulse; flushes the pipeline.
- `in0`, input, DATA_W. Unsigned integer operand.
- `out0`, output, DATA_W. Float result; registered; attribute `versat_latency = 3`.

## Operation
- Stage 1 (S1) registers `in0`.
- Stage 2 (S2):
  - lz = count of leading zeros of S1 (0..31).
  - Registers m = S1 << lz, so m[31] = 1 for nonzero input.
  - Registers exp = 158 − lz (bias 127 + 31).
  - Registers a zero flag.
- Stage 3 (S3) packs the result into `out0`:
  - Sign bit is always 0.
  - Mantissa = m[30:8], guard = m[7], sticky = |m[6:0].
  - Rounding per the Configuration section.
  - If rounding carries out of the mantissa: mantissa becomes 0 and exp becomes exp+1.
  - exp never exceeds 159, so no infinity and no NaN is produced.
- Zero input gives exactly 0x00000000.
- Inputs ≤ 2^24 are exact.
- Control:
  - `run`=1: all stage registers and `out0` are cleared to 0 at that edge. `run` has priority over `running`.
  - `running`=1, `run`=0: every stage advances.
  - `running`=0, `run`=0: every stage holds, including `out0`.
- Reset (`rst_n` low, at any time, including mid-pipeline): S1, S2, `out0` and the zero flag go to 0 immediately and stay 0 until the first advancing edge after release.

## Timing
- Latency: `in0` sampled at edge k appears on `out0` after edge k+2. That is 3 register stages; with `running` held high, the value is visible 3 cycles after presentation.
- Throughput: one conversion per cycle while `running`=1.
- Stalls (`running` low) stretch latency by the number of stalled edges; no data is lost or duplicated.
- Reset value of `out0`: 0x00000000.
- No combinational path from any input to `out0`.

## Configuration
- Macro `UINT2FLOAT_RNE_EN`.
- Defined: round-to-nearest-even. Increment when guard && (sticky || m[8]).
- Undefined: truncation (round toward zero). guard and sticky are ignored, no incrementer is built, and the carry path is removed.
- Latency is 3 in both builds.

## Structure
- Package `uint2float_pkg` holds:
  - constants `FP_EXP_W`=8, `FP_MAN_W`=23, `FP_BIAS`=127, `UINT_W`=32;
  - typedef `s2_t`: struct {zero, exp[7:0], m[31:0]}.
- Sub-module `uint2float_clz`: combinational 32-bit leading-zero counter (tree, 5-bit count plus an all-zero flag). Instantiated once in S2.
- Top holds the S1/S2/S3 registers and the round/pack logic.

## Test plan
- Reset, then `running`=1: drive 0x00000000, 0x00000001, 0x80000000 on consecutive cycles. Required `out0` 3 cycles later: 0x00000000, 0x3F800000, 0x4F000000 on consecutive cycles. `out0` reads 0 during reset.
- Exact/rounding boundary: 0x00FFFFFF gives 0x4B7FFFFF. 0x01000003 gives 0x4B800002 with `UINT2FLOAT_RNE_EN` defined, 0x4B800001 without.
- Carry-out: 0xFFFFFFFF gives 0x4F800000 (RNE), 0x4F7FFFFF (truncate).
- Stall: stream 1, 2, 3, 4 and drop `running` for 2 cycles mid-stream. `out0` holds its value during the stall. The sequence 0x3F800000, 0x40000000, 0x40400000, 0x40800000 emerges in order with no gaps or repeats once `running` resumes.
- Flush/reset mid-operation: pulse `run` while 3 values are in flight, then pulse `rst_n` low asynchronously mid-cycle. `out0` goes to 0 at the `run` edge and immediately on `rst_n`; no stale result appears afterwards.
- Random: 10k random 32-bit inputs compared against a reference model (C float cast for RNE, mantissa truncation otherwise), bit-exact.
